// File: rtl/mm_bram_parallel_ctrl_if.sv
// Bundle between the matrix-multiply control sequencer and its environment
// (host control, source SRAM read port, datapath issue and completion).
interface mm_bram_parallel_ctrl_if #(
  parameter int ROW_NUM = 32,
  parameter int COL_NUM = 32
);
  localparam int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int CNT_WIDTH      = $clog2(ROW_NUM + 1);

  // Handshake semantics: start is a request sampled only while the sequencer
  // is idle (busy=0, done=0); it is accepted on that edge, otherwise dropped.
  // src_rd_en and dpath_sum_en are valid-only strobes with no ready/back
  // pressure: one row per asserted cycle, address qualified by the strobe.
  // row_wr_en returns one completed row per cycle in which all bits are set.
  logic                      start;
  logic [CNT_WIDTH-1:0]      cfg_rows;
  logic                      busy;
  logic                      done;
  logic                      err;
  logic                      src_rd_en;
  logic [ROW_ADDR_WIDTH-1:0] src_rd_addr;
  logic                      dpath_sum_en;
  logic [ROW_ADDR_WIDTH-1:0] dpath_result_wraddr;
  logic [COL_NUM-1:0]        row_wr_en;

  modport master (
    input  start, cfg_rows, row_wr_en,
    output busy, done, err, src_rd_en, src_rd_addr,
           dpath_sum_en, dpath_result_wraddr
  );

  modport slave (
    output start, cfg_rows, row_wr_en,
    input  busy, done, err, src_rd_en, src_rd_addr,
           dpath_sum_en, dpath_result_wraddr
  );
endinterface

// File: rtl/mm_bram_parallel_ctrl.sv
// Control sequencer for the parallel matrix-multiply datapath: sweeps source
// rows, aligns sum-enable to SRAM read latency, counts row write-backs.
module mm_bram_parallel_ctrl #(
  parameter int ROW_NUM         = 32,
  parameter int COL_NUM         = 32,
  parameter int SRAM_RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  mm_bram_parallel_ctrl_if.master bus,
  output logic [1:0]              dbg_state
);
  localparam int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int CNT_WIDTH      = $clog2(ROW_NUM + 1);
  localparam int L              = SRAM_RD_LATENCY;
  localparam logic [CNT_WIDTH-1:0] ROWS_MAX = CNT_WIDTH'(ROW_NUM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                    state;
  state_t                    state_next;
  logic [CNT_WIDTH-1:0]      rows_q;
  logic [CNT_WIDTH-1:0]      issue_cnt;
  logic [CNT_WIDTH-1:0]      done_cnt;
  logic [CNT_WIDTH-1:0]      done_cnt_next;
  logic [CNT_WIDTH-1:0]      rows_clamped;
  logic                      err_q;
  logic [L-1:0]              pipe_vld;
  logic [ROW_ADDR_WIDTH-1:0] pipe_addr [L];

  logic                      start_acc;
  logic                      row_all;
  logic                      row_any;
  logic                      row_partial;
  logic                      counting;
  logic                      completion;
  logic                      done_full;
  logic                      pipe_empty;
  logic                      issue_last;
  logic                      err_set;
  logic                      src_en;
  logic [ROW_ADDR_WIDTH-1:0] src_addr;

  assign start_acc    = (state == IDLE) && bus.start;
  assign rows_clamped = (bus.cfg_rows > ROWS_MAX) ? ROWS_MAX : bus.cfg_rows;

  assign row_all     = &bus.row_wr_en;
  assign row_any     = |bus.row_wr_en;
  assign row_partial = row_any && !row_all;
  assign counting    = (state == ISSUE) || (state == DRAIN);
  assign completion  = counting && row_all;
  assign done_full   = (done_cnt == rows_q);
  assign pipe_empty  = (pipe_vld == '0);
  assign issue_last  = (issue_cnt == rows_q - CNT_ONE);

  // A completion arriving with every row already accounted for is a protocol
  // error and must not push done_cnt past rows_q.
  assign done_cnt_next = (completion && !done_full) ? done_cnt + CNT_ONE : done_cnt;
  assign err_set       = row_partial || (row_any && !counting) || (completion && done_full);

  assign src_en   = (state == ISSUE);
  assign src_addr = src_en ? issue_cnt[ROW_ADDR_WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-row run passes through DRAIN for one cycle so busy is seen high
  // for at least one cycle before the done pulse, like every other run.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_acc) begin
          state_next = (rows_clamped == '0) ? DRAIN : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if ((done_cnt_next == rows_q) && pipe_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_q    <= '0;
      issue_cnt <= '0;
      done_cnt  <= '0;
      err_q     <= 1'b0;
    end else if (start_acc) begin
      rows_q    <= rows_clamped;
      issue_cnt <= '0;
      done_cnt  <= '0;
      err_q     <= (bus.cfg_rows > ROWS_MAX) || err_set;
    end else begin
      if (src_en) begin
        issue_cnt <= issue_cnt + CNT_ONE;
      end
      done_cnt <= done_cnt_next;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  // Read-latency alignment: the read strobe and address travel together so
  // the datapath sees each row exactly when its SRAM data arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
      for (int i = 0; i < L; i++) begin
        pipe_addr[i] <= '0;
      end
    end else begin
      pipe_vld[0]  <= src_en;
      pipe_addr[0] <= src_addr;
      for (int i = 1; i < L; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign bus.busy                = counting;
  assign bus.done                = (state == DONE);
  assign bus.err                 = err_q;
  assign bus.src_rd_en           = src_en;
  assign bus.src_rd_addr         = src_addr;
  assign bus.dpath_sum_en        = pipe_vld[L-1];
  assign bus.dpath_result_wraddr = pipe_addr[L-1];
  assign dbg_state               = state;

  a_done_not_busy: assert property (@(posedge clk) disable iff (reset)
    bus.done |-> !bus.busy);

  a_addr_range: assert property (@(posedge clk) disable iff (reset)
    bus.src_rd_en |-> (bus.src_rd_addr <= ROW_ADDR_WIDTH'(ROW_NUM - 1)));

  a_done_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    done_cnt <= rows_q);
endmodule

// File: tb/tb_mm_bram_parallel_ctrl.sv
// Directed bench for mm_bram_parallel_ctrl: table-driven runs on an L=1
// instance plus hand-written error, abort and latency sequences.
module tb_mm_bram_parallel_ctrl;
  localparam int ROW_NUM = 32;
  localparam int COL_NUM = 32;
  localparam int CW      = 6;
  localparam int AW      = 5;
  localparam int W       = AW;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] dbg1;
  logic [1:0] dbg3;

  always #5 clk = ~clk;

  mm_bram_parallel_ctrl_if #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM)) bus1 ();
  mm_bram_parallel_ctrl_if #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM)) bus3 ();

  mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM), .SRAM_RD_LATENCY(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus1),
    .dbg_state (dbg1)
  );

  mm_bram_parallel_ctrl #(.ROW_NUM(ROW_NUM), .COL_NUM(COL_NUM), .SRAM_RD_LATENCY(3)) dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus3),
    .dbg_state (dbg3)
  );

  typedef struct {
    logic [CW-1:0] cfg;
    int            rows;
    int            done_cyc;
    logic          err;
    bit            noise;
  } vec_t;

  vec_t vecs [7];
  logic [W-1:0] exp_q [$];
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, exp);
  endtask

  task automatic chk_idle1(input string tag);
    chk({tag, "_busy"},  0, 32'(bus1.busy), 0);
    chk({tag, "_done"},  0, 32'(bus1.done), 0);
    chk({tag, "_src"},   0, 32'(bus1.src_rd_en), 0);
    chk({tag, "_addr"},  0, 32'(bus1.src_rd_addr), 0);
    chk({tag, "_sum"},   0, 32'(bus1.dpath_sum_en), 0);
    chk({tag, "_wadr"},  0, 32'(bus1.dpath_result_wraddr), 0);
  endtask

  // One complete run on the L=1 instance: datapath model answers all-ones
  // five cycles after each dpath_sum_en; wraddr order checked via exp_q.
  task automatic run_vec(input vec_t v);
    logic sum_hist [0:63];
    logic [W-1:0] e;
    for (int i = 0; i < 64; i++) sum_hist[i] = 1'b0;
    exp_q.delete();
    for (int i = 0; i < v.rows; i++) exp_q.push_back(W'(i));
    @(posedge clk); #1;
    bus1.start = 1'b1; bus1.cfg_rows = v.cfg; bus1.row_wr_en = '0;
    @(negedge clk);
    chk("c0_busy", 0, 32'(bus1.busy), 0);
    chk("c0_done", 0, 32'(bus1.done), 0);
    for (int c = 1; c <= v.done_cyc; c++) begin
      @(posedge clk); #1;
      bus1.start    = v.noise && (c == 3 || c == 5);
      bus1.cfg_rows = bus1.start ? 6'd3 : v.cfg;
      bus1.row_wr_en = '0;
      if (c >= 5) begin
        if (sum_hist[c-5]) bus1.row_wr_en = '1;
      end
      @(negedge clk);
      sum_hist[c] = bus1.dpath_sum_en;
      chk("src_rd_en", c, 32'(bus1.src_rd_en), 32'(c <= v.rows));
      if (c <= v.rows) chk("src_rd_addr", c, 32'(bus1.src_rd_addr), c - 1);
      chk("sum_en", c, 32'(bus1.dpath_sum_en), 32'(c >= 2 && c <= v.rows + 1));
      if (bus1.dpath_sum_en) begin
        if (exp_q.size() == 0) begin
          chk("wraddr_extra", c, 32'(bus1.dpath_result_wraddr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wraddr", c, 32'(bus1.dpath_result_wraddr), 32'(e));
        end
      end
      chk("busy", c, 32'(bus1.busy), 32'(c < v.done_cyc));
      chk("done", c, 32'(bus1.done), 32'(c == v.done_cyc));
      chk("err",  c, 32'(bus1.err), 32'(v.err));
    end
    chk("wraddr_left", v.done_cyc, exp_q.size(), 0);
    bus1.start = 1'b0; bus1.row_wr_en = '0;
  endtask

  initial begin
    vecs[0] = '{cfg: 6'd32, rows: 32, done_cyc: 39, err: 1'b0, noise: 1'b0};
    vecs[1] = '{cfg: 6'd1,  rows: 1,  done_cyc: 8,  err: 1'b0, noise: 1'b0};
    vecs[2] = '{cfg: 6'd5,  rows: 5,  done_cyc: 12, err: 1'b0, noise: 1'b0};
    vecs[3] = '{cfg: 6'd0,  rows: 0,  done_cyc: 2,  err: 1'b0, noise: 1'b0};
    vecs[4] = '{cfg: 6'd40, rows: 32, done_cyc: 39, err: 1'b1, noise: 1'b0};
    vecs[5] = '{cfg: 6'd17, rows: 17, done_cyc: 24, err: 1'b0, noise: 1'b0};
    vecs[6] = '{cfg: 6'd32, rows: 32, done_cyc: 39, err: 1'b0, noise: 1'b1};

    reset = 1'b1;
    bus1.start = 1'b0; bus1.cfg_rows = '0; bus1.row_wr_en = '0;
    bus3.start = 1'b0; bus3.cfg_rows = '0; bus3.row_wr_en = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_idle1("rst");
    chk("rst_err", 0, 32'(bus1.err), 0);
    chk("rst_state", 0, 32'(dbg1), 0);
    chk("rst3_busy", 0, 32'(bus3.busy), 0);
    chk("rst3_sum", 0, 32'(bus3.dpath_sum_en), 0);
    chk("rst3_state", 0, 32'(dbg3), 0);

    // Stray completion while idle.
    @(posedge clk); #1 bus1.row_wr_en = 32'h0000_0001;
    @(posedge clk); #1 bus1.row_wr_en = '0;
    @(negedge clk);
    chk("stray_err", 0, 32'(bus1.err), 1);
    chk("stray_busy", 0, 32'(bus1.busy), 0);

    // Back-to-back table runs: each start lands in the cycle after done.
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Latency 3 instance, 4 rows: sum_en on 4..7, completions on 9..12.
    @(posedge clk); #1 bus3.start = 1'b1; bus3.cfg_rows = 6'd4;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      bus3.start = 1'b0;
      bus3.row_wr_en = (c >= 9 && c <= 12) ? '1 : '0;
      @(negedge clk);
      chk("l3_src", c, 32'(bus3.src_rd_en), 32'(c <= 4));
      if (c <= 4) chk("l3_addr", c, 32'(bus3.src_rd_addr), c - 1);
      chk("l3_sum", c, 32'(bus3.dpath_sum_en), 32'(c >= 4 && c <= 7));
      if (c >= 4 && c <= 7) chk("l3_wadr", c, 32'(bus3.dpath_result_wraddr), c - 4);
      chk("l3_busy", c, 32'(bus3.busy), 32'(c < 13));
      chk("l3_done", c, 32'(bus3.done), 32'(c == 13));
      chk("l3_err", c, 32'(bus3.err), 0);
    end
    @(posedge clk); #1 bus3.row_wr_en = '0;

    // Partial write enable in place of the first completion: run hangs.
    @(posedge clk); #1 bus1.start = 1'b1; bus1.cfg_rows = 6'd4;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      bus1.start = 1'b0;
      if (c == 7) bus1.row_wr_en = 32'h0000_FFFF;
      else if (c >= 8 && c <= 10) bus1.row_wr_en = '1;
      else bus1.row_wr_en = '0;
      @(negedge clk);
      chk("part_err", c, 32'(bus1.err), 32'(c >= 8));
      chk("part_done", c, 32'(bus1.done), 0);
    end
    chk("part_busy", 20, 32'(bus1.busy), 1);
    chk("part_state", 20, 32'(dbg1), 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle1("part_rst");
    chk("part_rst_err", 0, 32'(bus1.err), 0);

    // Ignored starts while busy, then reset on cycle 10 aborts the run.
    @(posedge clk); #1 bus1.start = 1'b1; bus1.cfg_rows = 6'd32;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus1.start = (c == 3 || c == 5);
      bus1.cfg_rows = bus1.start ? 6'd3 : 6'd32;
      bus1.row_wr_en = (c >= 7) ? '1 : '0;
      if (c == 10) reset = 1'b1;
      @(negedge clk);
      chk("abort_addr", c, 32'(bus1.src_rd_addr), c - 1);
      chk("abort_busy", c, 32'(bus1.busy), 1);
      chk("abort_err", c, 32'(bus1.err), 0);
    end
    @(posedge clk); #1 reset = 1'b0; bus1.row_wr_en = '0; bus1.start = 1'b0;
    @(negedge clk);
    chk_idle1("abort_rst");
    chk("abort_rst_err", 11, 32'(bus1.err), 0);
    for (int c = 12; c <= 50; c++) begin
      @(negedge clk);
      chk("abort_nodone", c, 32'(bus1.done), 0);
      chk("abort_idle", c, 32'(bus1.busy), 0);
    end

    // Fresh run after the abort.
    run_vec(vecs[0]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
